// File: rtl/pcm_to_i2s_converter.sv
// I2S master transmitter (Philips format).
// Accepts 24-bit left/right PCM pairs over valid/ready. Generates bclk/lrclk
// from clk and shifts data out MSB-first on falling bclk edges, one bit
// after each lrclk edge. A single holding register decouples the upstream
// source from the frame timing. A pair offered on the transfer cycle while
// the holding register is empty is bypassed straight into the shifters.
module pcm_to_i2s_converter #(
  parameter int BCLK_HALF_DIV = 4,
  parameter int SLOT_BITS     = 32,
  parameter int DATA_BITS     = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        din_valid,
  input  logic [23:0] l_pcm_data,
  input  logic [23:0] r_pcm_data,
  output logic        din_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        i2s_data,
  output logic        frame_start,
  output logic        underflow
);

  localparam int DW = (BCLK_HALF_DIV > 2) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam int PW = $clog2(2 * SLOT_BITS);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF_DIV - 1);
  localparam logic [PW-1:0] P_LAST   = PW'(2 * SLOT_BITS - 1);
  localparam logic [PW-1:0] P_RSLOT  = PW'(SLOT_BITS);
  localparam logic [PW-1:0] P_LBEG   = PW'(1);
  localparam logic [PW-1:0] P_LEND   = PW'(DATA_BITS);
  localparam logic [PW-1:0] P_RBEG   = PW'(SLOT_BITS + 1);
  localparam logic [PW-1:0] P_REND   = PW'(SLOT_BITS + DATA_BITS);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic          r_bclk;
  logic [PW-1:0] r_p;
  logic          r_lrclk;
  logic          r_data;
  logic          r_fs;
  logic          r_uf;
  logic [23:0]   r_l_sr;
  logic [23:0]   r_r_sr;
  logic [23:0]   r_l_hold;
  logic [23:0]   r_r_hold;
  logic          r_full;

  logic          w_div_tc;
  logic          w_shift;
  logic [PW-1:0] w_p_next;
  logic          w_xfer;
  logic          w_accept;
  logic          w_hold_load;
  logic          w_in_left;
  logic          w_in_right;

  // Divider terminal count, shift event (bclk 1->0) and next frame position.
  assign w_div_tc    = (r_div == DIV_LAST);
  assign w_shift     = (r_state == S_RUN) & w_div_tc & r_bclk;
  assign w_p_next    = (r_p == P_LAST) ? '0 : r_p + PW'(1);
  // Transfer happens on the shift event that wraps the frame to p=0.
  assign w_xfer      = enable & w_shift & (w_p_next == '0);
  // Handshake; on a transfer cycle an accepted pair bypasses the holding reg.
  assign w_accept    = din_valid & ~r_full;
  assign w_hold_load = w_accept & ~w_xfer;
  // Data windows: one-bit delay after each lrclk edge, DATA_BITS long.
  assign w_in_left   = (w_p_next >= P_LBEG) & (w_p_next <= P_LEND);
  assign w_in_right  = (w_p_next >= P_RBEG) & (w_p_next <= P_REND);

  // Holding register: filled on a non-transfer accept, drained by a transfer.
  // It survives enable=0 so a pair can be preloaded while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full   <= 1'b0;
      r_l_hold <= '0;
      r_r_hold <= '0;
    end else if (w_xfer && r_full) begin
      r_full <= 1'b0;
    end else if (w_hold_load) begin
      r_full   <= 1'b1;
      r_l_hold <= l_pcm_data;
      r_r_hold <= r_pcm_data;
    end
  end

  // IDLE/RUN control, bit-clock divider, frame position and serialiser.
  // Dropping enable aborts the current frame and returns to idle values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bclk  <= 1'b0;
      r_p     <= P_LAST;
      r_lrclk <= 1'b0;
      r_data  <= 1'b0;
      r_fs    <= 1'b0;
      r_uf    <= 1'b0;
      r_l_sr  <= '0;
      r_r_sr  <= '0;
    end else begin
      r_fs <= 1'b0;
      r_uf <= 1'b0;
      if (!enable) begin
        r_state <= S_IDLE;
        r_div   <= '0;
        r_bclk  <= 1'b0;
        r_p     <= P_LAST;
        r_lrclk <= 1'b0;
        r_data  <= 1'b0;
        r_l_sr  <= '0;
        r_r_sr  <= '0;
      end else begin
        r_state <= S_RUN;
        if (w_div_tc) begin
          r_div  <= '0;
          r_bclk <= ~r_bclk;
        end else begin
          r_div <= r_div + DW'(1);
        end

        if (w_shift) begin
          r_p     <= w_p_next;
          r_lrclk <= (w_p_next >= P_RSLOT);
          if (w_p_next == '0) begin
            // Frame transfer: holding reg, else bypassed input, else silence.
            r_data <= 1'b0;
            r_fs   <= 1'b1;
            if (r_full) begin
              r_l_sr <= r_l_hold;
              r_r_sr <= r_r_hold;
            end else if (din_valid) begin
              r_l_sr <= l_pcm_data;
              r_r_sr <= r_pcm_data;
            end else begin
              r_l_sr <= '0;
              r_r_sr <= '0;
              r_uf   <= 1'b1;
            end
          end else if (w_in_left) begin
            r_data <= r_l_sr[23];
            r_l_sr <= {r_l_sr[22:0], 1'b0};
          end else if (w_in_right) begin
            r_data <= r_r_sr[23];
            r_r_sr <= {r_r_sr[22:0], 1'b0};
          end else begin
            r_data <= 1'b0;
          end
        end
      end
    end
  end

  assign din_ready   = ~r_full;
  assign bclk        = r_bclk;
  assign lrclk       = r_lrclk;
  assign i2s_data    = r_data;
  assign frame_start = r_fs;
  assign underflow   = r_uf;

endmodule

// File: tb/tb_pcm_to_i2s_converter.sv
// Directed bench for pcm_to_i2s_converter with BCLK_HALF_DIV=2 (bclk = 4 clk,
// frame = 64 bclk = 256 clk). Outputs are sampled 1 time unit after posedge.
module tb_pcm_to_i2s_converter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        din_valid;
  logic [23:0] l_pcm_data;
  logic [23:0] r_pcm_data;
  logic        din_ready;
  logic        bclk;
  logic        lrclk;
  logic        i2s_data;
  logic        frame_start;
  logic        underflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fs = 0;

  logic [23:0] pl [3] = '{24'h123456, 24'hFEDCBA, 24'h800001};
  logic [23:0] pr [3] = '{24'hC3C3C3, 24'h0F0F0F, 24'h7FFFFE};

  localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

  pcm_to_i2s_converter #(
    .BCLK_HALF_DIV(2),
    .SLOT_BITS(32),
    .DATA_BITS(24)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .din_valid(din_valid),
    .l_pcm_data(l_pcm_data),
    .r_pcm_data(r_pcm_data),
    .din_ready(din_ready),
    .bclk(bclk),
    .lrclk(lrclk),
    .i2s_data(i2s_data),
    .frame_start(frame_start),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected slot bits: L MSB-first at slots 1..24, R at 33..56, else 0.
  function automatic logic [63:0] exp_bits(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] v;
    v = '0;
    for (int j = 1; j <= 24; j++) begin
      v[j]      = l[24-j];
      v[32 + j] = r[24-j];
    end
    return v;
  endfunction

  task automatic wait_fs(output bit ok, output int period);
    ok = 1'b0;
    period = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        period = cyc - last_fs;
        last_fs = cyc;
        break;
      end
    end
  endtask

  // Record i2s_data/lrclk at each of the next n bclk rising edges.
  task automatic capture(input int n, output logic [63:0] d, output logic [63:0] lr,
                         output int ufc, output bit ok);
    logic prev;
    logic rise;
    int guard;
    d = '0;
    lr = '0;
    ufc = 0;
    ok = 1'b1;
    prev = bclk;
    for (int j = 0; j < n; j++) begin
      guard = 0;
      rise = 1'b0;
      do begin
        step();
        if (underflow === 1'b1) ufc++;
        rise = (bclk === 1'b1) && (prev === 1'b0);
        prev = bclk;
        guard++;
      end while (!rise && guard < 20);
      if (!rise) begin
        ok = 1'b0;
        break;
      end
      d[j]  = i2s_data;
      lr[j] = lrclk;
    end
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] lr;
    int ufc;
    int per;
    bit ok;

    reset_n = 1'b0;
    enable = 1'b0;
    din_valid = 1'b0;
    l_pcm_data = '0;
    r_pcm_data = '0;

    // Reset values
    step();
    step();
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_data", i2s_data, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_ready", din_ready, 1);
    reset_n = 1'b1;
    step();

    // Preload A5A5A5/5A5A5A while idle, then enable and check startup timing
    din_valid = 1'b1;
    l_pcm_data = 24'hA5A5A5;
    r_pcm_data = 24'h5A5A5A;
    step();
    din_valid = 1'b0;
    chk("preload_ready_low", din_ready, 0);
    chk("idle_bclk", bclk, 0);
    enable = 1'b1;
    step();
    chk("start_bclk_e1", bclk, 0);
    step();
    chk("start_bclk_rise", bclk, 1);
    step();
    chk("start_fs_e3", frame_start, 0);
    step();
    chk("start_bclk_fall", bclk, 0);
    chk("start_fs", frame_start, 1);
    chk("start_uf", underflow, 0);
    chk("start_ready", din_ready, 1);
    last_fs = cyc;
    capture(64, d, lr, ufc, ok);
    chk("a5_cap_ok", ok, 1);
    chk("a5_data", d, exp_bits(24'hA5A5A5, 24'h5A5A5A));
    chk("a5_lrclk", lr, LR_EXP);

    // Two frames with no sample: one underflow per frame, silent data
    for (int f = 0; f < 2; f++) begin
      wait_fs(ok, per);
      chk("uf_fs_seen", ok, 1);
      chk("uf_pulse", underflow, 1);
      chk("frame_period", per, 256);
      capture(64, d, lr, ufc, ok);
      chk("uf_cap_ok", ok, 1);
      chk("uf_data_zero", d, 0);
      chk("uf_lrclk", lr, LR_EXP);
      chk("uf_mid_frame", ufc, 0);
    end

    // Bypass: pair presented only on the transfer cycle
    step();
    din_valid = 1'b1;
    l_pcm_data = 24'h3C0FF1;
    r_pcm_data = 24'hE10203;
    step();
    din_valid = 1'b0;
    chk("byp_fs", frame_start, 1);
    chk("byp_no_uf", underflow, 0);
    chk("byp_ready", din_ready, 1);
    capture(64, d, lr, ufc, ok);
    chk("byp_data", d, exp_bits(24'h3C0FF1, 24'hE10203));

    // Three pairs back-to-back with din_valid held
    fork
      begin
        int g;
        for (int k = 0; k < 3; k++) begin
          l_pcm_data = pl[k];
          r_pcm_data = pr[k];
          din_valid = 1'b1;
          g = 0;
          do begin
            @(negedge clk);
            g++;
          end while (din_ready !== 1'b1 && g < 600);
          chk("feed_ready", din_ready, 1);
          if (k > 0) chk("ready_rise_at_xfer", frame_start, 1);
          @(posedge clk);
          #1;
        end
        din_valid = 1'b0;
      end
      begin
        logic [63:0] bd;
        logic [63:0] blr;
        int bufc;
        int bper;
        bit bok;
        for (int k = 0; k < 3; k++) begin
          wait_fs(bok, bper);
          chk("b2b_fs", bok, 1);
          chk("b2b_no_uf", underflow, 0);
          capture(64, bd, blr, bufc, bok);
          chk("b2b_data", bd, exp_bits(pl[k], pr[k]));
        end
      end
    join

    // Enable dropped at p=40 with a pending pair, then restarted
    wait_fs(ok, per);
    chk("pre_drop_uf", underflow, 1);
    din_valid = 1'b1;
    l_pcm_data = 24'h9ABCDE;
    r_pcm_data = 24'h13579B;
    step();
    din_valid = 1'b0;
    chk("drop_preload", din_ready, 0);
    capture(40, d, lr, ufc, ok);
    chk("drop_cap_ok", ok, 1);
    step();
    step();
    chk("p40_lrclk", lrclk, 1);
    enable = 1'b0;
    step();
    chk("drop_bclk", bclk, 0);
    chk("drop_lrclk", lrclk, 0);
    chk("drop_data", i2s_data, 0);
    chk("drop_hold_kept", din_ready, 0);
    step();
    step();
    step();
    enable = 1'b1;
    step();
    step();
    chk("restart_bclk", bclk, 1);
    step();
    step();
    chk("restart_fs", frame_start, 1);
    chk("restart_no_uf", underflow, 0);
    chk("restart_ready", din_ready, 1);
    capture(64, d, lr, ufc, ok);
    chk("restart_data", d, exp_bits(24'h9ABCDE, 24'h13579B));

    // Asynchronous reset mid-frame with enable high and a pending pair
    wait_fs(ok, per);
    din_valid = 1'b1;
    l_pcm_data = 24'h111111;
    r_pcm_data = 24'h222222;
    step();
    din_valid = 1'b0;
    capture(40, d, lr, ufc, ok);
    chk("pre_rst_bclk", bclk, 1);
    chk("pre_rst_lrclk", lrclk, 1);
    chk("pre_rst_ready", din_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("arst_bclk", bclk, 0);
    chk("arst_lrclk", lrclk, 0);
    chk("arst_data", i2s_data, 0);
    chk("arst_ready", din_ready, 1);
    #2;
    reset_n = 1'b1;
    #1;
    chk("rel_bclk", bclk, 0);
    chk("rel_lrclk", lrclk, 0);
    step();
    step();
    step();
    step();
    chk("post_rst_fs", frame_start, 1);
    chk("post_rst_uf", underflow, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
